// File: rtl/timer_pkg.sv
// Shared constants for the timer APB bridge.
// Register map defaults and bridge FSM encodings.
package timer_pkg;

  localparam int TIMER_ADDR_W = 6;
  localparam int TIMER_DATA_W = 8;

  localparam logic [5:0] CNTR_ADDR = 6'h04;

  localparam int unsigned ADDR_LIMIT_DEF = 'h10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/timer_apb_bridge.sv
// APB3 slave front-end for the timer register block.
// Define TIMER_APB_PSLVERR_EN to error out-of-range addresses.
module timer_apb_bridge
  import timer_pkg::*;
#(
  parameter int          ADDR_W     = TIMER_ADDR_W,
  parameter int          DATA_W     = TIMER_DATA_W,
  parameter int          RD_WAIT    = 1,
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              wr_en,
  output logic              mod_en,
  input  logic [DATA_W-1:0] rdata
);

  localparam int CW = $clog2(RD_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(RD_WAIT);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(ADDR_LIMIT);

`ifdef TIMER_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic setup;
  logic valid;
  logic last;
  logic st_acc;
  logic st_rd;
  logic st_resp;

  assign setup   = psel & ~penable;
  assign valid   = psel & penable;
  assign last    = (cnt_q == CW'(1));
  assign st_acc  = (state_q == ST_ACC);
  assign st_rd   = (state_q == ST_RD);
  assign st_resp = (state_q == ST_RESP);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    dir_d    = dir_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          dir_d   = pwrite;
          err_d   = ERR_EN & ({1'b0, paddr} >= LIM);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (!valid || err_q || dir_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = WAIT_LD;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (!valid) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // rdata has been stable for RD_WAIT cycles by the last RD cycle
          if (last) begin
            prdata_d = rdata;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake outputs are gated by the live access phase so aborts stay silent
  assign mod_en  = st_acc | st_rd;
  assign wr_en   = valid & st_acc & dir_q & ~err_q;
  assign pready  = valid & ((st_acc & (dir_q | err_q)) | st_resp);
  assign pslverr = valid & st_acc & err_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign prdata  = prdata_q;

endmodule
